brick_wall_engine: RTL
======================

// Module: brick_wall_engine
// PURPOSE
//  Parametrised Breakout playfield engine: bordered field, ROWS x COLS brick wall, bouncing square ball.
//  Brick hits are latched: a brick that has been hit stays off until reset or the next serve.
//  Sits between the VGA sync counter (pixelX/pixelY) and the RGB output mux.
//  Outputs per-pixel colour and game status.
// PARAMETERS
//  BRICK_COLS   5    bricks per row (1..8)
//  BRICK_ROWS   2    brick rows (1..4); NB = BRICK_ROWS*BRICK_COLS
//  BRICK_W      70   brick width, px
//  BRICK_H      10   brick height, px
//  BRICK_PITCH  120  horizontal brick pitch, px (left edge to left edge)
//  ROW_PITCH    16   vertical row pitch, px
//  WALL_X0      60   left edge of brick col 0, px
//  WALL_Y0      52   top edge of brick row 0, px
//  BALL_SIZE    10   ball side length, px
//  SPEED        1    px moved per frame, per axis (1..7)
//  FIELD_L/R    52/630  inner playfield x limits, inclusive
//  FIELD_T/B    43/470  inner playfield y limits, inclusive
//  START_X/Y    320/400  ball top-left after reset/serve
//  BOTTOM_KILL  0    0 = bottom wall bounces; 1 = touching bottom ends the game
// PORTS
//  clock        in   1   pixel clock
//  reset        in   1   synchronous, active-low reset
//  pixelX       in   10  current scan x
//  pixelY       in   10  current scan y
//  serve        in   1   start/restart request, level-sampled
//  objRed       out  4   pixel red
//  objGreen     out  4   pixel green
//  objBlue      out  4   pixel blue
//  bricks_left  out  6   count of bricks still on
//  hit_pulse    out  1   one-cycle pulse when a brick is cleared
//  game_over    out  1   high in the WON or LOST state
// BEHAVIOUR
//  Reset (reset==0 at a clock edge):
//   - state IDLE; ball at START_X/Y; dx=+, dy=- ; all NB bricks on; bricks_left=NB.
//   - RGB=0; hit_pulse=0; game_over=0.
//  tick = (pixelY==481 && pixelX==0). All motion and collision updates happen only on tick.
//  State machine:
//   - IDLE -> PLAY on serve==1 at a tick. On that serve, ball and bricks are re-initialised as at reset.
//   - PLAY -> WON when bricks_left reaches 0.
//   - PLAY -> LOST when BOTTOM_KILL=1 and the moved ball's bottom is >= FIELD_B.
//   - WON/LOST -> IDLE on serve==1 at a tick.
//   - In IDLE, WON and LOST the ball is frozen.
//  Motion in PLAY, per tick, each axis independently:
//   - Candidate position = pos +/- SPEED.
//   - If the candidate would cross a field limit: flip that axis' direction and hold the position for that frame.
//   - A bottom-limit hit with BOTTOM_KILL=1 is a loss, not a bounce.
//  Brick collision, evaluated in the same tick as motion, on the candidate position:
//   - Hit = ball rectangle overlaps an "on" brick rectangle (inclusive bounds).
//   - If several bricks overlap, clear only the lowest index (idx = row*BRICK_COLS + col).
//   - A brick hit flips dy. A brick hit and a wall bounce in one tick both apply.
//   - On a hit: bricks_left decrements by 1 and hit_pulse is high for exactly 1 cycle.
//  Pixel path, 1-cycle latency:
//   - RGB is registered from the pixelX/pixelY sampled in the previous cycle.
//   - Priority: border > on-brick > ball > black.
//   - Border (0,F,0) = band 10 px outside the field limits.
//   - Brick colour by row mod 4: row0 D/F/4, row1 D/5/C, row2 5/9/1, row3 6/D/9.
//   - Ball colour F/F/0.
//  Arithmetic: positions are 10-bit unsigned. All comparisons are done in 11 bits so no wrap occurs at 0 or 1023.
//  serve held high: acts once per transition.
//  Reset mid-frame or mid-game: state returns to reset values on the next edge, with no residual hit_pulse.
// TESTING
//  1 Reset low 2 cycles, release -> state IDLE; bricks_left=10; ball at (320,400); pixel (65,55) is D/F/4 one cycle later.
//  2 serve=1 then 1 tick -> PLAY; ball at (321,399). After 3 further ticks -> ball at (324,396).
//  3 Ball forced to (620,300) moving +x, SPEED=1, 1 tick -> dx flips; x stays 620. Next tick -> x=619.
//  4 Ball driven into brick 0 -> hit_pulse 1 cycle; bricks_left 10->9; dy flips; pixel (65,55) black afterwards.
//  5 Ball overlapping bricks 0 and 5 together -> only brick 0 cleared; bricks_left decrements by exactly 1.
//  6 BOTTOM_KILL=1, ball reaches y=461 moving down -> LOST; game_over=1; ball frozen. serve -> IDLE; all bricks on.

Source files
------------

// File: rtl/brick_wall_engine.sv
// Breakout playfield engine: bordered field, latched brick wall and a bouncing ball,
// advanced once per frame and rendered one pixel per clock with one cycle of latency.
module brick_wall_engine #(
    parameter int BRICK_COLS  = 5,
    parameter int BRICK_ROWS  = 2,
    parameter int BRICK_W     = 70,
    parameter int BRICK_H     = 10,
    parameter int BRICK_PITCH = 120,
    parameter int ROW_PITCH   = 16,
    parameter int WALL_X0     = 60,
    parameter int WALL_Y0     = 52,
    parameter int BALL_SIZE   = 10,
    parameter int SPEED       = 1,
    parameter int FIELD_L     = 52,
    parameter int FIELD_R     = 630,
    parameter int FIELD_T     = 43,
    parameter int FIELD_B     = 470,
    parameter int START_X     = 320,
    parameter int START_Y     = 400,
    parameter int BOTTOM_KILL = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [9:0] pixelX,
    input  logic [9:0] pixelY,
    input  logic       serve,
    output logic [3:0] objRed,
    output logic [3:0] objGreen,
    output logic [3:0] objBlue,
    output logic [5:0] bricks_left,
    output logic       hit_pulse,
    output logic       game_over
);

    localparam int NB = BRICK_ROWS * BRICK_COLS;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PLAY = 2'd1;
    localparam logic [1:0] S_WON  = 2'd2;
    localparam logic [1:0] S_LOST = 2'd3;

    localparam logic [10:0] FL   = 11'(FIELD_L);
    localparam logic [10:0] FR   = 11'(FIELD_R);
    localparam logic [10:0] FT   = 11'(FIELD_T);
    localparam logic [10:0] FB   = 11'(FIELD_B);
    localparam logic [10:0] SP   = 11'(SPEED);
    localparam logic [10:0] BS1  = 11'(BALL_SIZE - 1);
    localparam logic [10:0] BW1  = 11'(BRICK_W - 1);
    localparam logic [10:0] BH1  = 11'(BRICK_H - 1);
    localparam logic [10:0] BAND = 11'd10;
    localparam logic [9:0]  X0   = 10'(START_X);
    localparam logic [9:0]  Y0   = 10'(START_Y);
    localparam logic [5:0]  NB6  = 6'(NB);

    function automatic logic [10:0] brick_left_edge(input int col);
        return 11'(WALL_X0 + col * BRICK_PITCH);
    endfunction

    function automatic logic [10:0] brick_top_edge(input int row);
        return 11'(WALL_Y0 + row * ROW_PITCH);
    endfunction

    function automatic logic [11:0] row_colour(input int row);
        case (row % 4)
            0:       return 12'hDF4;
            1:       return 12'hD5C;
            2:       return 12'h591;
            default: return 12'h6D9;
        endcase
    endfunction

    logic [1:0]    state_q, state_d;
    logic [9:0]    ball_x_q, ball_x_d, ball_y_q, ball_y_d;
    logic          dx_q, dx_d, dy_q, dy_d;
    logic [NB-1:0] brick_q, brick_d;
    logic [5:0]    left_q, left_d;
    logic          hit_q, hit_d;
    logic          over_q, over_d;
    logic          serve_last_q, serve_last_d;
    logic [11:0]   rgb_q, rgb_d;

    logic          tick_s, kill_s, wall_x_s, wall_y_s, bottom_s, hit_any_s;
    logic [10:0]   pos_x_s, pos_y_s, cand_x_s, cand_y_s;
    logic [NB-1:0] overlap_s, hit_mask_s;
    logic [10:0]   px_s, py_s;
    logic          outer_s, inner_s, ball_pix_s, brick_pix_s, in_brick_s;
    logic [11:0]   brick_rgb_s;

    assign tick_s = (pixelY == 10'd481) && (pixelX == 10'd0);

    // Candidate move, wall contacts and the lowest-index live brick touched by the candidate ball.
    always_comb begin
        pos_x_s = {1'b0, ball_x_q};
        pos_y_s = {1'b0, ball_y_q};
        // Direction bits: 1 moves toward larger coordinates.
        if (dx_q) begin
            cand_x_s = pos_x_s + SP;
            wall_x_s = (cand_x_s + BS1 >= FR);
        end else begin
            cand_x_s = pos_x_s - SP;
            wall_x_s = (pos_x_s <= FL + SP);
        end
        if (dy_q) begin
            cand_y_s = pos_y_s + SP;
            bottom_s = (cand_y_s + BS1 >= FB);
            wall_y_s = bottom_s && (BOTTOM_KILL == 0);
        end else begin
            cand_y_s = pos_y_s - SP;
            bottom_s = 1'b0;
            wall_y_s = (pos_y_s <= FT + SP);
        end
        kill_s    = bottom_s && (BOTTOM_KILL != 0);
        overlap_s = '0;
        for (int r = 0; r < BRICK_ROWS; r++) begin
            for (int c = 0; c < BRICK_COLS; c++) begin
                overlap_s[r*BRICK_COLS + c] = brick_q[r*BRICK_COLS + c]
                    && (cand_x_s <= brick_left_edge(c) + BW1) && (cand_x_s + BS1 >= brick_left_edge(c))
                    && (cand_y_s <= brick_top_edge(r) + BH1)  && (cand_y_s + BS1 >= brick_top_edge(r));
            end
        end
        hit_mask_s = overlap_s & (~overlap_s + NB'(1));
        hit_any_s  = |overlap_s;
    end

    // Frame-rate game state: serve handling, ball motion, brick clearing and win/loss.
    always_comb begin
        state_d      = state_q;
        ball_x_d     = ball_x_q;
        ball_y_d     = ball_y_q;
        dx_d         = dx_q;
        dy_d         = dy_q;
        brick_d      = brick_q;
        left_d       = left_q;
        hit_d        = 1'b0;
        serve_last_d = tick_s ? serve : serve_last_q;
        if (!tick_s) begin
            state_d = state_q;
        end else if (serve && !serve_last_q && (state_q != S_PLAY)) begin
            // A fresh serve rebuilds the wall and recentres the ball on the way in and out of a game.
            ball_x_d = X0;
            ball_y_d = Y0;
            dx_d     = 1'b1;
            dy_d     = 1'b0;
            brick_d  = '1;
            left_d   = NB6;
            state_d  = (state_q == S_IDLE) ? S_PLAY : S_IDLE;
        end else if (state_q == S_PLAY) begin
            ball_x_d = wall_x_s ? ball_x_q : cand_x_s[9:0];
            ball_y_d = wall_y_s ? ball_y_q : cand_y_s[9:0];
            dx_d     = dx_q ^ wall_x_s;
            dy_d     = dy_q ^ wall_y_s ^ hit_any_s;
            brick_d  = brick_q & ~hit_mask_s;
            left_d   = left_q - {5'd0, hit_any_s};
            hit_d    = hit_any_s;
            if (hit_any_s && (left_q == 6'd1)) begin
                state_d = S_WON;
            end else if (kill_s) begin
                state_d = S_LOST;
            end else begin
                state_d = S_PLAY;
            end
        end else begin
            state_d = state_q;
        end
        over_d = (state_d == S_WON) || (state_d == S_LOST);
    end

    // Pixel colour for this cycle's scan position: border, then live bricks, then ball.
    always_comb begin
        px_s        = {1'b0, pixelX};
        py_s        = {1'b0, pixelY};
        outer_s     = (px_s >= FL - BAND) && (px_s <= FR + BAND) && (py_s >= FT - BAND) && (py_s <= FB + BAND);
        inner_s     = (px_s >= FL) && (px_s <= FR) && (py_s >= FT) && (py_s <= FB);
        ball_pix_s  = (px_s >= pos_x_s) && (px_s <= pos_x_s + BS1) && (py_s >= pos_y_s) && (py_s <= pos_y_s + BS1);
        brick_pix_s = 1'b0;
        brick_rgb_s = 12'h000;
        in_brick_s  = 1'b0;
        for (int r = 0; r < BRICK_ROWS; r++) begin
            for (int c = 0; c < BRICK_COLS; c++) begin
                in_brick_s  = brick_q[r*BRICK_COLS + c]
                    && (px_s >= brick_left_edge(c)) && (px_s <= brick_left_edge(c) + BW1)
                    && (py_s >= brick_top_edge(r))  && (py_s <= brick_top_edge(r) + BH1);
                brick_pix_s = brick_pix_s | in_brick_s;
                brick_rgb_s = brick_rgb_s | ({12{in_brick_s}} & row_colour(r));
            end
        end
        if (outer_s && !inner_s) begin
            rgb_d = 12'h0F0;
        end else if (brick_pix_s) begin
            rgb_d = brick_rgb_s;
        end else if (ball_pix_s) begin
            rgb_d = 12'hFF0;
        end else begin
            rgb_d = 12'h000;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            ball_x_q     <= X0;
            ball_y_q     <= Y0;
            dx_q         <= 1'b1;
            dy_q         <= 1'b0;
            brick_q      <= '1;
            left_q       <= NB6;
            hit_q        <= 1'b0;
            over_q       <= 1'b0;
            serve_last_q <= 1'b0;
            rgb_q        <= 12'h000;
        end else begin
            state_q      <= state_d;
            ball_x_q     <= ball_x_d;
            ball_y_q     <= ball_y_d;
            dx_q         <= dx_d;
            dy_q         <= dy_d;
            brick_q      <= brick_d;
            left_q       <= left_d;
            hit_q        <= hit_d;
            over_q       <= over_d;
            serve_last_q <= serve_last_d;
            rgb_q        <= rgb_d;
        end
    end

    assign objRed      = rgb_q[11:8];
    assign objGreen    = rgb_q[7:4];
    assign objBlue     = rgb_q[3:0];
    assign bricks_left = left_q;
    assign hit_pulse   = hit_q;
    assign game_over   = over_q;

endmodule
